// File: rtl/lora_frame_if.sv
// Byte-in / display-out bundle between the UART receiver, lora_frame_ctrl and the scanner.
// err_cnt exists only when LORA_FRAME_STATS_EN is defined.
interface lora_frame_if;
  logic [7:0] rx_byte;
  logic       rx_vld;
  logic [7:0] disp_val;
  logic       disp_vld;
  logic       alarm;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;
`ifdef LORA_FRAME_STATS_EN
  logic [7:0] err_cnt;

  modport master (
    output rx_byte, rx_vld,
    input  disp_val, disp_vld, alarm, frame_ok, frame_err, busy, err_cnt
  );
  modport slave (
    input  rx_byte, rx_vld,
    output disp_val, disp_vld, alarm, frame_ok, frame_err, busy, err_cnt
  );
`else
  modport master (
    output rx_byte, rx_vld,
    input  disp_val, disp_vld, alarm, frame_ok, frame_err, busy
  );
  modport slave (
    input  rx_byte, rx_vld,
    output disp_val, disp_vld, alarm, frame_ok, frame_err, busy
  );
`endif
endinterface

// File: rtl/lora_frame_ctrl.sv
// Assembles HEADER/CMD/VAL/CHK frames from the UART byte stream and drives display value and alarm.
// Optional saturating error counter on bus.err_cnt under LORA_FRAME_STATS_EN.
module lora_frame_ctrl #(
  parameter int         CLK_FREQ      = 50_000_000,
  parameter int         BAUD          = 115200,
  parameter int         TIMEOUT_BYTES = 4,
  parameter logic [7:0] HEADER        = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         over_all,
  lora_frame_if.slave  bus
);

  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int TO_CYC  = BIT_CYC * 10 * TIMEOUT_BYTES;
  localparam int CNT_W   = $clog2(TO_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_VAL  = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       cmd_r;
  logic [7:0]       val_r;
  logic [7:0]       disp_val_r;
  logic             disp_vld_r;
  logic             alarm_r;
  logic             frame_ok_r;
  logic             frame_err_r;
  logic             busy_r;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] val);
    return cmd + val;
  endfunction

  // Frame sequencer, inter-byte timeout and command evaluation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      cmd_r       <= 8'h00;
      val_r       <= 8'h00;
      disp_val_r  <= 8'h00;
      disp_vld_r  <= 1'b0;
      alarm_r     <= 1'b0;
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      frame_ok_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (over_all) begin
        state_r    <= S_IDLE;
        busy_r     <= 1'b0;
        cnt_r      <= '0;
        disp_val_r <= 8'h00;
        disp_vld_r <= 1'b0;
        alarm_r    <= 1'b0;
      end else if (bus.rx_vld) begin
        cnt_r <= '0;
        case (state_r)
          S_IDLE: begin
            if (bus.rx_byte == HEADER) begin
              state_r <= S_CMD;
              busy_r  <= 1'b1;
            end else begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end
          end
          S_CMD: begin
            cmd_r   <= bus.rx_byte;
            state_r <= S_VAL;
            busy_r  <= 1'b1;
          end
          S_VAL: begin
            val_r   <= bus.rx_byte;
            state_r <= S_CHK;
            busy_r  <= 1'b1;
          end
          S_CHK: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            if (frame_chk(cmd_r, val_r) != bus.rx_byte) begin
              frame_err_r <= 1'b1;
            end else begin
              case (cmd_r)
                8'h01: begin
                  disp_val_r <= val_r;
                  disp_vld_r <= 1'b1;
                  frame_ok_r <= 1'b1;
                end
                8'h02: begin
                  alarm_r    <= (val_r != 8'h00);
                  frame_ok_r <= 1'b1;
                end
                8'h03: begin
                  disp_val_r <= 8'h00;
                  disp_vld_r <= 1'b0;
                  alarm_r    <= 1'b0;
                  frame_ok_r <= 1'b1;
                end
                default: frame_err_r <= 1'b1;
              endcase
            end
          end
          default: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end else if (state_r == S_IDLE) begin
        cnt_r <= '0;
      end else if (cnt_r == TO_LAST) begin
        // Gap too long: abandon the partial frame and report it
        state_r     <= S_IDLE;
        busy_r      <= 1'b0;
        cnt_r       <= '0;
        frame_err_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.disp_val  = disp_val_r;
  assign bus.disp_vld  = disp_vld_r;
  assign bus.alarm     = alarm_r;
  assign bus.frame_ok  = frame_ok_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

`ifdef LORA_FRAME_STATS_EN
  logic [7:0] err_cnt_r;

  // Saturating error tally; deliberately survives over_all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (frame_err_r && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign bus.err_cnt = err_cnt_r;
`else
`endif

endmodule

// File: tb/tb_lora_frame_ctrl.sv
// Self-checking bench for lora_frame_ctrl: vector table, hand sequences and a randomized model run.
module tb_lora_frame_ctrl;

  localparam int TO_CYC = (50_000_000 / 115200) * 10 * 4;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic over_all = 1'b0;

  lora_frame_if bus ();

  lora_frame_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .over_all (over_all),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int exp_errs  = 0;

  typedef struct {
    logic [31:0] bytes;
    logic [7:0]  dv;
    logic        vld;
    logic        alarm;
    logic        ok;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  // Reference model: bytes of the frame in progress plus architectural outputs
  logic [7:0] mq [$];
  logic [7:0] m_dv;
  logic       m_vld;
  logic       m_alarm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] dv, input logic vld,
                            input logic al, input logic ok, input logic err);
    check({tag, "_disp_val"},  bus.disp_val,  dv);
    check({tag, "_disp_vld"},  bus.disp_vld,  vld);
    check({tag, "_alarm"},     bus.alarm,     al);
    check({tag, "_frame_ok"},  bus.frame_ok,  ok);
    check({tag, "_frame_err"}, bus.frame_err, err);
  endtask

  function automatic logic [31:0] sat_errs(input int n);
    return (n > 255) ? 32'd255 : 32'(n);
  endfunction

  // Called at a negedge; returns at the next negedge with the byte consumed
  task automatic strobe(input logic [7:0] b);
    bus.rx_byte = b;
    bus.rx_vld  = 1'b1;
    @(negedge clk);
    bus.rx_vld  = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic ok, output logic err);
    logic [7:0] sum;
    ok  = 1'b0;
    err = 1'b0;
    if (mq.size() != 0 || b == 8'hA5) begin
      mq.push_back(b);
      if (mq.size() == 4) begin
        sum = mq[1] + mq[2];
        if (sum != mq[3]) begin
          err = 1'b1;
        end else if (mq[1] == 8'h01) begin
          m_dv = mq[2]; m_vld = 1'b1; ok = 1'b1;
        end else if (mq[1] == 8'h02) begin
          m_alarm = (mq[2] != 8'h00); ok = 1'b1;
        end else if (mq[1] == 8'h03) begin
          m_dv = 8'h00; m_vld = 1'b0; m_alarm = 1'b0; ok = 1'b1;
        end else begin
          err = 1'b1;
        end
        mq.delete();
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    logic        seen;
    int          n;

    vecs[0] = '{32'hA5011F20, 8'h1F, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'hA5014F50, 8'h4F, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'hA5014400, 8'h4F, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'hA5020103, 8'h4F, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'hA5071017, 8'h4F, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'hA5020002, 8'h4F, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'hA501A5A6, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'hA5030003, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'hA501FF00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};

    bus.rx_byte = 8'h00;
    bus.rx_vld  = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table, frames back-to-back
    for (int i = 0; i < 9; i++) begin
      w = vecs[i].bytes;
      strobe(w[31:24]);
      check("vec_busy_hdr", bus.busy, 1'b1);
      strobe(w[23:16]);
      strobe(w[15:8]);
      check("vec_no_pulse", bus.frame_ok | bus.frame_err, 1'b0);
      strobe(w[7:0]);
      check_outs("vec", vecs[i].dv, vecs[i].vld, vecs[i].alarm, vecs[i].ok, vecs[i].err);
      check("vec_busy_end", bus.busy, 1'b0);
      if (vecs[i].err) exp_errs++;
    end
    @(negedge clk);
    check("vec_pulse_1clk", bus.frame_ok | bus.frame_err, 1'b0);
    @(negedge clk);
`ifdef LORA_FRAME_STATS_EN
    check("err_cnt_vec", bus.err_cnt, sat_errs(exp_errs));
`endif

    // Leading garbage is dropped silently
    strobe(8'h1F);
    check("garbage_err", bus.frame_err, 1'b0);
    strobe(8'h4F);
    check("garbage_busy", bus.busy, 1'b0);
    strobe(8'hA5); strobe(8'h01); strobe(8'h44); strobe(8'h45);
    check_outs("garbage", 8'h44, 1'b1, 1'b0, 1'b1, 1'b0);

    // Timeout after a partial frame
    strobe(8'hA5); strobe(8'h01);
    seen = 1'b0;
    n    = 0;
    for (int k = 1; k <= TO_CYC + 50 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) check("timeout_busy_pre", bus.busy, 1'b1);
      if (bus.frame_err) begin
        seen = 1'b1;
        n    = k;
      end
    end
    check("timeout_at", n, TO_CYC);
    check("timeout_busy", bus.busy, 1'b0);
    check("timeout_keep_val", bus.disp_val, 8'h44);
    exp_errs++;
    @(negedge clk);
    check("timeout_pulse_1clk", bus.frame_err, 1'b0);
    strobe(8'hA5); strobe(8'h03); strobe(8'h00); strobe(8'h03);
    check_outs("clear", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    // Randomized run against the model
    mq.delete();
    m_dv = 8'h00; m_vld = 1'b0; m_alarm = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] b;
      logic       eo;
      logic       ee;
      if ($urandom_range(0, 19) == 0) begin
        over_all    = 1'b1;
        bus.rx_byte = 8'($urandom);
        bus.rx_vld  = 1'($urandom_range(0, 1));
        @(negedge clk);
        over_all   = 1'b0;
        bus.rx_vld = 1'b0;
        mq.delete();
        m_dv = 8'h00; m_vld = 1'b0; m_alarm = 1'b0;
        eo = 1'b0; ee = 1'b0;
      end else begin
        case (mq.size())
          0:       b = ($urandom_range(0, 4) != 0) ? 8'hA5 : 8'($urandom);
          1:       b = 8'($urandom_range(0, 4));
          2:       b = 8'($urandom);
          default: b = ($urandom_range(0, 3) != 0) ? 8'(mq[1] + mq[2]) : 8'($urandom);
        endcase
        strobe(b);
        model_byte(b, eo, ee);
        if (ee) exp_errs++;
      end
      check_outs("rand", m_dv, m_vld, m_alarm, eo, ee);
      check("rand_busy", bus.busy, mq.size() != 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("rand_idle_pulse", bus.frame_ok | bus.frame_err, 1'b0);
      end
    end
    repeat (2) @(negedge clk);
`ifdef LORA_FRAME_STATS_EN
    check("err_cnt_rand", bus.err_cnt, sat_errs(exp_errs));
`endif

    // over_all clear, including a byte strobe in the same cycle
    over_all = 1'b1;
    @(negedge clk);
    over_all = 1'b0;
    strobe(8'hA5); strobe(8'h02); strobe(8'h01); strobe(8'h03);
    check_outs("alarm_set", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    over_all = 1'b1;
    strobe(8'hA5);
    over_all = 1'b0;
    check_outs("over_all", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("over_all_busy", bus.busy, 1'b0);
    strobe(8'h01); strobe(8'h1F); strobe(8'h20);
    check_outs("over_all_discard", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LORA_FRAME_STATS_EN
    // Saturation of the error counter
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("err_cnt_reset", bus.err_cnt, 8'h00);
    for (int i = 0; i < 257; i++) begin
      strobe(8'hA5); strobe(8'h01); strobe(8'h44); strobe(8'h00);
      check("sat_frame_err", bus.frame_err, 1'b1);
    end
    repeat (2) @(negedge clk);
    check("err_cnt_sat", bus.err_cnt, 8'hFF);
    over_all = 1'b1;
    @(negedge clk);
    over_all = 1'b0;
    @(negedge clk);
    check("err_cnt_keep_over_all", bus.err_cnt, 8'hFF);
`endif

    // Reset mid-frame aborts without a pulse
    strobe(8'hA5); strobe(8'h01); strobe(8'h30);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_busy", bus.busy, 1'b0);
`ifdef LORA_FRAME_STATS_EN
    check("rst_err_cnt", bus.err_cnt, 8'h00);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    strobe(8'h31);
    check_outs("rst_after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_after_busy", bus.busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
